// File: rtl/expu_pkg.sv
// Shared constants and stage-1 record for the bfloat16 log2 unit.
package expu_pkg;

    localparam int LOGU_W     = 16;
    localparam int LOGU_EXP   = 8;
    localparam int LOGU_MAN   = 7;
    localparam int LOGU_BIAS  = 127;

    // Q8.12 signed log value and its magnitude width
    localparam int LOGU_Q_W    = 21;
    localparam int LOGU_Q_FRAC = 12;
    localparam int LOGU_MAG_W  = LOGU_Q_W - 1;

    localparam logic [LOGU_W-1:0] LOGU_QNAN = 16'h7FC0;
    localparam logic [LOGU_W-1:0] LOGU_PINF = 16'h7F80;
    localparam logic [LOGU_W-1:0] LOGU_NINF = 16'hFF80;

    localparam int LOGU_CORR_K = 11;

    typedef struct packed {
        logic                special;
        logic [LOGU_W-1:0]   sval;
        logic [LOGU_Q_W-1:0] t;
    } logu_s1_t;

endpackage

// File: rtl/fpnew_pkg.sv
// Minimal floating-point format descriptors used to size the log unit.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e f);
        case (f)
            FP32:          return 32;
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            default:       return 8;
        endcase
    endfunction

    function automatic int unsigned exp_bits(input fp_format_e f);
        case (f)
            FP32, FP16ALT: return 8;
            FP64:          return 11;
            default:       return 5;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e f);
        case (f)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP16ALT: return 7;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/logu_row.sv
// One lane of the log2 pipe: S1 decode + fixed-point log, S2 normalise + pack.
// Mantissa correction term compiled in with LOGU_MANT_CORRECTION_EN.
import expu_pkg::*;

module logu_row (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en_s1,
    input  logic              i_en_s2,
    input  logic [LOGU_W-1:0] i_op,
    output logic [LOGU_W-1:0] o_res
);

    logic                  w_s;
    logic [LOGU_EXP-1:0]   w_e;
    logic [LOGU_MAN-1:0]   w_m;
    logic [LOGU_Q_W-1:0]   w_corr;
    logic [LOGU_Q_W-1:0]   w_t;
    logu_s1_t              w_s1;
    logu_s1_t              r_s1;

    assign w_s = i_op[LOGU_W-1];
    assign w_e = i_op[LOGU_W-2 -: LOGU_EXP];
    assign w_m = i_op[LOGU_MAN-1:0];

`ifdef LOGU_MANT_CORRECTION_EN
    logic [LOGU_Q_W-1:0] w_prod;
    assign w_prod = LOGU_Q_W'(w_m) * LOGU_Q_W'(8'd128 - {1'b0, w_m}) * LOGU_Q_W'(LOGU_CORR_K);
    assign w_corr = w_prod >> 7;
`else
    assign w_corr = '0;
`endif

    // Two's complement wrap gives the signed Q8.12 value directly
    assign w_t = (({13'b0, w_e} - LOGU_Q_W'(LOGU_BIAS)) << LOGU_Q_FRAC)
               + {9'b0, w_m, 5'b0} + w_corr;

    always_comb begin
        w_s1         = '0;
        w_s1.t       = w_t;
        if (w_e == '0) begin
            w_s1.special = 1'b1;
            w_s1.sval    = LOGU_NINF;
        end else if (w_e == '1) begin
            w_s1.special = 1'b1;
            w_s1.sval    = (w_m != '0 || w_s) ? LOGU_QNAN : LOGU_PINF;
        end else if (w_s) begin
            w_s1.special = 1'b1;
            w_s1.sval    = LOGU_QNAN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_s1 <= '0;
        else if (i_en_s1) r_s1 <= w_s1;
    end

    logic                  w_neg;
    logic [LOGU_MAG_W-1:0] w_mag;
    logic [4:0]            w_p;
    logic [LOGU_MAG_W-1:0] w_norm;
    logic [LOGU_EXP-1:0]   w_exp;
    logic [LOGU_W-1:0]     w_res;
    logic [LOGU_W-1:0]     r_res;

    assign w_neg = r_s1.t[LOGU_Q_W-1];
    assign w_mag = w_neg ? LOGU_MAG_W'(-r_s1.t) : r_s1.t[LOGU_MAG_W-1:0];

    always_comb begin
        w_p = '0;
        for (int i = 0; i < LOGU_MAG_W; i++)
            if (w_mag[i]) w_p = 5'(i);
    end

    // Leading one moved to the MSB; the 7 bits below it are the mantissa
    assign w_norm = w_mag << (5'(LOGU_MAG_W - 1) - w_p);
    assign w_exp  = 8'(LOGU_BIAS - LOGU_Q_FRAC) + {3'b0, w_p};

    always_comb begin
        w_res = '0;
        if (r_s1.special)
            w_res = r_s1.sval;
        else if (w_mag != '0)
            w_res = {w_neg, w_exp, w_norm[LOGU_MAG_W-2 -: LOGU_MAN]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_res <= '0;
        else if (i_en_s2) r_res <= w_res;
    end

    assign o_res = r_res;

endmodule

// File: rtl/logu_top.sv
// N_ROWS-lane bfloat16 approximate log2, 2-stage pipe with valid/ready handshake.
// Optional mantissa correction: define LOGU_MANT_CORRECTION_EN.
module logu_top
    import fpnew_pkg::*;
    import expu_pkg::*;
#(
    parameter fp_format_e  FPFORMAT      = FP16ALT,
    parameter int          N_ROWS        = 16,
    localparam int unsigned WIDTH         = fp_width(FPFORMAT),
    localparam int unsigned MANTISSA_BITS = man_bits(FPFORMAT),
    localparam int unsigned EXPONENT_BITS = exp_bits(FPFORMAT)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [N_ROWS-1:0][WIDTH-1:0] op_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [N_ROWS-1:0][WIDTH-1:0] res_o
);

    if (FPFORMAT != FP16ALT || MANTISSA_BITS != LOGU_MAN || EXPONENT_BITS != LOGU_EXP) begin : g_bad_fmt
        $error("logu_top: only FP16ALT is supported");
    end

    logic w_adv;
    logic r_v1;
    logic r_v2;

    // Whole pipe moves together; it stalls only when the output is held
    assign w_adv   = ready_i | ~r_v2;
    assign ready_o = w_adv;
    assign valid_o = r_v2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (clear_i) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= valid_i;
            r_v2 <= r_v1;
        end
    end

    for (genvar g = 0; g < N_ROWS; g++) begin : g_row
        logu_row u_row (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_en_s1 (w_adv & valid_i),
            .i_en_s2 (w_adv & r_v1),
            .i_op    (op_i[g]),
            .o_res   (res_o[g])
        );
    end

endmodule
